// File: rtl/preg_ready_table.sv
// Ready-bit table for physical registers. Writebacks set bits and allocations clear them.
// Branch checkpoints hold table snapshots so a mispredict can restore readiness in one cycle.
module preg_ready_table #(
    parameter int NUM_PREGS     = 64,
    parameter int PREG_IDX_BITS = 6,
    parameter int NUM_CMP       = 3,
    parameter int NUM_ALLOC     = 3,
    parameter int NUM_RD        = 6,
    parameter int NUM_CKPT      = 4,
    parameter int CKPT_IDX_BITS = 2,
    parameter int RESET_READY   = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CMP-1:0]                 cmp_valid,
    input  logic [NUM_CMP*PREG_IDX_BITS-1:0]   cmp_idx,
    input  logic [NUM_ALLOC-1:0]               alloc_valid,
    input  logic [NUM_ALLOC*PREG_IDX_BITS-1:0] alloc_idx,
    input  logic [NUM_RD*PREG_IDX_BITS-1:0]    rd_idx,
    output logic [NUM_RD-1:0]                  rd_ready,
    input  logic                               ckpt_save,
    input  logic [CKPT_IDX_BITS-1:0]           ckpt_save_id,
    input  logic                               ckpt_free,
    input  logic [CKPT_IDX_BITS-1:0]           ckpt_free_id,
    input  logic                               ckpt_restore,
    input  logic [CKPT_IDX_BITS-1:0]           ckpt_restore_id,
    output logic [NUM_CKPT-1:0]                ckpt_valid,
    output logic                               restore_err,
    output logic [NUM_PREGS-1:0]               ready_vec
);

    function automatic logic [NUM_PREGS-1:0] reset_vec();
        logic [NUM_PREGS-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_PREGS; j++) begin
            v[j] = (j < RESET_READY) || (j == 0);
        end
        return v;
    endfunction

    localparam logic [NUM_PREGS-1:0] RESET_VEC = reset_vec();

    logic [NUM_PREGS-1:0]                ready_q, ready_d;
    logic [NUM_CKPT-1:0][NUM_PREGS-1:0]  snap_q, snap_d;
    logic [NUM_CKPT-1:0]                 ckpt_valid_q, ckpt_valid_d;
    logic                                restore_err_q, restore_err_d;

    logic [NUM_PREGS-1:0]     cmp_mask;
    logic [NUM_PREGS-1:0]     alloc_mask;
    logic [PREG_IDX_BITS-1:0] rd_sel;
    logic                     restore_hit;

    always_comb begin
        cmp_mask   = '0;
        alloc_mask = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            if (cmp_valid[i]) cmp_mask[cmp_idx[i*PREG_IDX_BITS +: PREG_IDX_BITS]] = 1'b1;
        end
        for (int i = 0; i < NUM_ALLOC; i++) begin
            if (alloc_valid[i]) alloc_mask[alloc_idx[i*PREG_IDX_BITS +: PREG_IDX_BITS]] = 1'b1;
        end
    end

    // Reads see the current table plus this cycle's writebacks; allocations are not bypassed.
    always_comb begin
        rd_ready = '0;
        rd_sel   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_sel      = rd_idx[i*PREG_IDX_BITS +: PREG_IDX_BITS];
            rd_ready[i] = ready_q[rd_sel] | cmp_mask[rd_sel] | (rd_sel == '0);
        end
    end

    always_comb begin
        restore_hit   = ckpt_restore && ckpt_valid_q[ckpt_restore_id];
        restore_err_d = ckpt_restore && !ckpt_valid_q[ckpt_restore_id];

        if (restore_hit) begin
            ready_d = snap_q[ckpt_restore_id] | cmp_mask;
        end else begin
            ready_d = (ready_q & ~alloc_mask) | cmp_mask;
        end
        ready_d[0] = 1'b1;

        snap_d       = snap_q;
        ckpt_valid_d = ckpt_valid_q;
        for (int s = 0; s < NUM_CKPT; s++) begin
            // A fresh save already contains this cycle's completions; live slots absorb them.
            if (!restore_hit && ckpt_save && (ckpt_save_id == CKPT_IDX_BITS'(s))) begin
                snap_d[s] = ready_d;
            end else if (ckpt_valid_q[s]) begin
                snap_d[s] = snap_q[s] | cmp_mask;
            end

            if (restore_hit) begin
                ckpt_valid_d[s] = 1'b0;
            end else begin
                if (ckpt_free && (ckpt_free_id == CKPT_IDX_BITS'(s))) ckpt_valid_d[s] = 1'b0;
                if (ckpt_save && (ckpt_save_id == CKPT_IDX_BITS'(s))) ckpt_valid_d[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q       <= RESET_VEC;
            snap_q        <= '0;
            ckpt_valid_q  <= '0;
            restore_err_q <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            snap_q        <= snap_d;
            ckpt_valid_q  <= ckpt_valid_d;
            restore_err_q <= restore_err_d;
        end
    end

    assign ready_vec   = ready_q;
    assign ckpt_valid  = ckpt_valid_q;
    assign restore_err = restore_err_q;

endmodule

// File: tb/tb_preg_ready_table.sv
// Bench for preg_ready_table: directed scenarios plus random traffic checked
// against a per-register rule model of the ready table and its checkpoints.
module tb_preg_ready_table;
  localparam int NP = 64;
  localparam int IB = 6;
  localparam int NC = 3;
  localparam int NA = 3;
  localparam int NR = 6;
  localparam int NK = 4;
  localparam int KB = 2;

  logic clock = 1'b0;
  logic reset;
  logic [NC-1:0] cmp_valid;
  logic [NC*IB-1:0] cmp_idx;
  logic [NA-1:0] alloc_valid;
  logic [NA*IB-1:0] alloc_idx;
  logic [NR*IB-1:0] rd_idx;
  logic [NR-1:0] rd_ready;
  logic ckpt_save;
  logic [KB-1:0] ckpt_save_id;
  logic ckpt_free;
  logic [KB-1:0] ckpt_free_id;
  logic ckpt_restore;
  logic [KB-1:0] ckpt_restore_id;
  logic [NK-1:0] ckpt_valid;
  logic restore_err;
  logic [NP-1:0] ready_vec;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_ready[NP];
  bit m_snap[NK][NP];
  bit m_valid[NK];
  bit m_err;

  preg_ready_table dut (
    .clock(clock), .reset(reset),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .rd_idx(rd_idx), .rd_ready(rd_ready),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_free(ckpt_free), .ckpt_free_id(ckpt_free_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .ckpt_valid(ckpt_valid), .restore_err(restore_err), .ready_vec(ready_vec)
  );

  always #5 clock = ~clock;

  // ---------------- model ----------------
  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_ready[p] = (p < 32);
    for (int s = 0; s < NK; s++) begin
      m_valid[s] = 0;
      for (int p = 0; p < NP; p++) m_snap[s][p] = 0;
    end
    m_err = 0;
  endtask

  function automatic bit is_cmp(int p);
    for (int i = 0; i < NC; i++)
      if (cmp_valid[i] && int'(cmp_idx[i*IB +: IB]) == p) return 1;
    return 0;
  endfunction

  function automatic bit is_alloc(int p);
    for (int i = 0; i < NA; i++)
      if (alloc_valid[i] && int'(alloc_idx[i*IB +: IB]) == p) return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit nr[NP];
    bit ns[NK][NP];
    bit nv[NK];
    bit restoring;
    int rid, sid, fid;
    rid = int'(ckpt_restore_id);
    sid = int'(ckpt_save_id);
    fid = int'(ckpt_free_id);
    restoring = ckpt_restore && m_valid[rid];
    for (int p = 0; p < NP; p++) begin
      if (p == 0) nr[p] = 1;
      else if (restoring) nr[p] = m_snap[rid][p] || is_cmp(p);
      else if (is_cmp(p)) nr[p] = 1;
      else if (is_alloc(p)) nr[p] = 0;
      else nr[p] = m_ready[p];
    end
    for (int s = 0; s < NK; s++) begin
      for (int p = 0; p < NP; p++) begin
        if (!restoring && ckpt_save && sid == s) ns[s][p] = nr[p];
        else if (m_valid[s]) ns[s][p] = m_snap[s][p] || is_cmp(p);
        else ns[s][p] = m_snap[s][p];
      end
      if (restoring) nv[s] = 0;
      else if (ckpt_save && sid == s) nv[s] = 1;
      else if (ckpt_free && fid == s) nv[s] = 0;
      else nv[s] = m_valid[s];
    end
    m_err = ckpt_restore && !m_valid[rid];
    m_ready = nr;
    m_snap = ns;
    m_valid = nv;
  endtask

  function automatic logic [NP-1:0] exp_vec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = m_ready[p];
    return v;
  endfunction

  function automatic logic [NK-1:0] exp_valid();
    logic [NK-1:0] v;
    for (int s = 0; s < NK; s++) v[s] = m_valid[s];
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    cmp_valid = '0; cmp_idx = '0;
    alloc_valid = '0; alloc_idx = '0;
    rd_idx = '0;
    ckpt_save = 0; ckpt_save_id = '0;
    ckpt_free = 0; ckpt_free_id = '0;
    ckpt_restore = 0; ckpt_restore_id = '0;
  endtask

  task automatic set_cmp(int port, int idx);
    cmp_valid[port] = 1'b1;
    cmp_idx[port*IB +: IB] = IB'(idx);
  endtask

  task automatic set_alloc(int port, int idx);
    alloc_valid[port] = 1'b1;
    alloc_idx[port*IB +: IB] = IB'(idx);
  endtask

  task automatic set_rd(int port, int idx);
    rd_idx[port*IB +: IB] = IB'(idx);
  endtask

  // Settle inputs, check bypass reads, clock one edge, check registered outputs.
  task automatic cycle();
    int ri;
    bit er;
    #1;
    for (int i = 0; i < NR; i++) begin
      ri = int'(rd_idx[i*IB +: IB]);
      er = m_ready[ri] || is_cmp(ri) || (ri == 0);
      checks++;
      if (rd_ready[i] !== er) begin
        errors++;
        $display("FAIL rd_ready[%0d] idx=%0d got=%b exp=%b t=%0t", i, ri, rd_ready[i], er, $time);
      end
    end
    model_step();
    @(posedge clock);
    #1;
    checks++;
    if (ready_vec !== exp_vec()) begin
      errors++;
      $display("FAIL ready_vec got=%h exp=%h t=%0t", ready_vec, exp_vec(), $time);
    end
    checks++;
    if (ckpt_valid !== exp_valid()) begin
      errors++;
      $display("FAIL ckpt_valid got=%b exp=%b t=%0t", ckpt_valid, exp_valid(), $time);
    end
    checks++;
    if (restore_err !== m_err) begin
      errors++;
      $display("FAIL restore_err got=%b exp=%b t=%0t", restore_err, m_err, $time);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    set_rd(0, 40);
    set_rd(1, 0);
    #1;
    checks++;
    if (ready_vec !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_ready_vec got=%h exp=%h", ready_vec, 64'h0000_0000_FFFF_FFFF);
    end
    checks++;
    if (ckpt_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ckpt_valid got=%b exp=0000", ckpt_valid);
    end
    checks++;
    if (rd_ready[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL reset_rd_ready got=%b exp=10", rd_ready[1:0]);
    end
    cycle();
  endtask

  task automatic test_alloc_cmp();
    clear_inputs();
    set_alloc(0, 40); set_alloc(1, 41);
    set_rd(0, 40);
    cycle();
    clear_inputs();
    set_cmp(2, 40);
    set_rd(0, 40); set_rd(1, 41);
    #1;
    checks++;
    if (rd_ready[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL bypass_rd_ready got=%b exp=01", rd_ready[1:0]);
    end
    cycle();
    checks++;
    if (ready_vec[41:40] !== 2'b01) begin
      errors++;
      $display("FAIL alloc_cmp_bits got=%b exp=01", ready_vec[41:40]);
    end
  endtask

  task automatic test_collision();
    clear_inputs();
    set_alloc(0, 0); set_cmp(0, 0);
    set_alloc(1, 45); set_cmp(1, 45);
    set_rd(0, 45);
    cycle();
    checks++;
    if ({ready_vec[45], ready_vec[0]} !== 2'b11) begin
      errors++;
      $display("FAIL collision_bits got=%b exp=11", {ready_vec[45], ready_vec[0]});
    end
  endtask

  task automatic test_ckpt_restore();
    clear_inputs();
    set_alloc(0, 50); ckpt_save = 1; ckpt_save_id = 2;
    cycle();
    clear_inputs();
    set_alloc(1, 51);
    cycle();
    clear_inputs();
    set_cmp(0, 50);
    cycle();
    clear_inputs();
    ckpt_restore = 1; ckpt_restore_id = 2;
    set_rd(0, 50); set_rd(1, 51);
    cycle();
    checks++;
    if ({ready_vec[51], ready_vec[50], ckpt_valid} !== 6'b01_0000) begin
      errors++;
      $display("FAIL restore_bits got=%b exp=010000", {ready_vec[51], ready_vec[50], ckpt_valid});
    end
  endtask

  task automatic test_restore_cmp();
    clear_inputs();
    set_cmp(0, 53);
    cycle();
    clear_inputs();
    ckpt_save = 1; ckpt_save_id = 0;
    ckpt_free = 1; ckpt_free_id = 3;
    cycle();
    clear_inputs();
    ckpt_save = 1; ckpt_save_id = 1;
    cycle();
    clear_inputs();
    ckpt_restore = 1; ckpt_restore_id = 0;
    set_cmp(1, 52); set_alloc(2, 53);
    ckpt_save = 1; ckpt_save_id = 3;
    cycle();
    checks++;
    if ({ready_vec[53], ready_vec[52], ckpt_valid} !== 6'b11_0000) begin
      errors++;
      $display("FAIL restore_cmp_bits got=%b exp=110000", {ready_vec[53], ready_vec[52], ckpt_valid});
    end
  endtask

  task automatic test_restore_err();
    clear_inputs();
    ckpt_restore = 1; ckpt_restore_id = 1;
    set_alloc(0, 20); set_cmp(0, 55);
    cycle();
    checks++;
    if ({restore_err, ready_vec[55], ready_vec[20]} !== 3'b110) begin
      errors++;
      $display("FAIL restore_err_pulse got=%b exp=110", {restore_err, ready_vec[55], ready_vec[20]});
    end
    clear_inputs();
    cycle();
    checks++;
    if (restore_err !== 1'b0) begin
      errors++;
      $display("FAIL restore_err_clear got=%b exp=0", restore_err);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_alloc(0, 5); ckpt_save = 1; ckpt_save_id = 3;
    cycle();
    clear_inputs();
    ckpt_restore = 1; ckpt_restore_id = 2;
    cycle();
    clear_inputs();
    ckpt_restore = 1; ckpt_restore_id = 3;
    set_cmp(0, 60);
    #2;
    reset = 1;
    #1;
    model_reset();
    checks++;
    if ({ready_vec, ckpt_valid, restore_err} !== {64'h0000_0000_FFFF_FFFF, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got=%h/%b/%b exp=00000000ffffffff/0000/0", ready_vec, ckpt_valid, restore_err);
    end
    #1;
    reset = 0;
    clear_inputs();
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 1)) set_cmp(i, ($urandom_range(0, 3) == 0) ? $urandom_range(40, 47) : $urandom_range(0, 63));
      for (int i = 0; i < NA; i++)
        if ($urandom_range(0, 1)) set_alloc(i, ($urandom_range(0, 3) == 0) ? $urandom_range(40, 47) : $urandom_range(0, 63));
      for (int i = 0; i < NR; i++)
        set_rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(40, 47) : $urandom_range(0, 63));
      ckpt_save = ($urandom_range(0, 3) == 0);
      ckpt_save_id = KB'($urandom_range(0, 3));
      ckpt_free = ($urandom_range(0, 3) == 0);
      ckpt_free_id = KB'($urandom_range(0, 3));
      ckpt_restore = ($urandom_range(0, 7) == 0);
      ckpt_restore_id = KB'($urandom_range(0, 3));
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_alloc_cmp();
    test_collision();
    test_ckpt_restore();
    test_restore_cmp();
    test_restore_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
